// File: rtl/fifo_axis_out.sv
// rtl/fifo_axis_out.sv - packet-framing FIFO drain to an AXI4-Stream master
//
// Pops a header entry (beat count in fifo_data[LEN_WIDTH-1:0]) from a
// fall-through FIFO, then forwards that many data entries as AXI4-Stream
// beats, marking the final beat with axis_tlast. A 2-entry output buffer
// keeps axis_tready off the combinational path to fifo_pop.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   fifo_valid/data/pop  fall-through FIFO head and pop strobe
//   axis_tvalid/tdata/tlast/tready  AXI4-Stream master
//   busy                 mid-packet or output buffer holding beats
//   len_err              sticky: a zero-length header was discarded
//   pkt_cnt              (FIFO_AXIS_OUT_PKT_CNT_EN only) completed packets
//
// Optional feature macro: FIFO_AXIS_OUT_PKT_CNT_EN

module fifo_axis_out #(
    parameter int WIDTH     = 32,
    parameter int LEN_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_valid,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_pop,
    output logic             axis_tvalid,
    output logic [WIDTH-1:0] axis_tdata,
    output logic             axis_tlast,
    input  logic             axis_tready,
    output logic             busy,
    output logic             len_err
`ifdef FIFO_AXIS_OUT_PKT_CNT_EN
    ,
    output logic [31:0]      pkt_cnt
`endif
);

    typedef enum logic {S_HDR, S_DATA} state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] remain_q, remain_d;
    logic [WIDTH-1:0]     buf0_data_q, buf0_data_d;
    logic [WIDTH-1:0]     buf1_data_q, buf1_data_d;
    logic                 buf0_last_q, buf0_last_d;
    logic                 buf1_last_q, buf1_last_d;
    logic [1:0]           buf_cnt_q, buf_cnt_d;
    logic                 len_err_q, len_err_d;
    logic [LEN_WIDTH-1:0] hdr_len;
    logic                 push;
    logic                 push_last;
    logic                 xfer;
`ifdef FIFO_AXIS_OUT_PKT_CNT_EN
    logic [31:0]          pkt_cnt_q, pkt_cnt_d;
`endif

    assign hdr_len = fifo_data[LEN_WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        buf0_data_d = buf0_data_q;
        buf1_data_d = buf1_data_q;
        buf0_last_d = buf0_last_q;
        buf1_last_d = buf1_last_q;
        buf_cnt_d   = buf_cnt_q;
        len_err_d   = len_err_q;
        fifo_pop    = 1'b0;
        push        = 1'b0;
        push_last   = (remain_q == LEN_ONE);
        xfer        = (buf_cnt_q != 2'd0) && axis_tready;

        case (state_q)
            S_HDR: begin
                // Header pop never waits for buffer space; it is not forwarded.
                if (fifo_valid) begin
                    fifo_pop = 1'b1;
                    if (hdr_len == '0) begin
                        len_err_d = 1'b1;
                    end else begin
                        remain_d = hdr_len;
                        state_d  = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // Only the registered count gates the pop, so tready never
                // reaches fifo_pop combinationally.
                if (fifo_valid && (buf_cnt_q < 2'd2)) begin
                    fifo_pop = 1'b1;
                    push     = 1'b1;
                    if (remain_q != '0) begin
                        remain_d = remain_q - LEN_ONE;
                    end
                    if (push_last) begin
                        state_d = S_HDR;
                    end
                end
            end
            default: state_d = S_HDR;
        endcase

        // Entry 0 is always the head; a transfer shifts entry 1 forward.
        case ({push, xfer})
            2'b10: begin
                if (buf_cnt_q == 2'd0) begin
                    buf0_data_d = fifo_data;
                    buf0_last_d = push_last;
                end else begin
                    buf1_data_d = fifo_data;
                    buf1_last_d = push_last;
                end
                buf_cnt_d = buf_cnt_q + 2'd1;
            end
            2'b01: begin
                buf0_data_d = buf1_data_q;
                buf0_last_d = buf1_last_q;
                buf_cnt_d   = buf_cnt_q - 2'd1;
            end
            2'b11: begin
                if (buf_cnt_q == 2'd1) begin
                    buf0_data_d = fifo_data;
                    buf0_last_d = push_last;
                end else begin
                    buf0_data_d = buf1_data_q;
                    buf0_last_d = buf1_last_q;
                    buf1_data_d = fifo_data;
                    buf1_last_d = push_last;
                end
            end
            default: ;
        endcase

        // The upstream FIFO is not reset with us, so never pop during reset.
        if (!rst_n) begin
            fifo_pop = 1'b0;
        end
    end

`ifdef FIFO_AXIS_OUT_PKT_CNT_EN
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (xfer && buf0_last_q) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HDR;
            remain_q    <= '0;
            buf0_data_q <= '0;
            buf1_data_q <= '0;
            buf0_last_q <= 1'b0;
            buf1_last_q <= 1'b0;
            buf_cnt_q   <= 2'd0;
            len_err_q   <= 1'b0;
`ifdef FIFO_AXIS_OUT_PKT_CNT_EN
            pkt_cnt_q   <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            buf0_data_q <= buf0_data_d;
            buf1_data_q <= buf1_data_d;
            buf0_last_q <= buf0_last_d;
            buf1_last_q <= buf1_last_d;
            buf_cnt_q   <= buf_cnt_d;
            len_err_q   <= len_err_d;
`ifdef FIFO_AXIS_OUT_PKT_CNT_EN
            pkt_cnt_q   <= pkt_cnt_d;
`endif
        end
    end

    assign axis_tvalid = (buf_cnt_q != 2'd0);
    assign axis_tdata  = buf0_data_q;
    assign axis_tlast  = buf0_last_q;
    assign busy        = (state_q == S_DATA) || (buf_cnt_q != 2'd0);
    assign len_err     = len_err_q;
`ifdef FIFO_AXIS_OUT_PKT_CNT_EN
    assign pkt_cnt     = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_axis_out.sv
// tb/tb_fifo_axis_out.sv - self-checking bench for fifo_axis_out

module tb_fifo_axis_out;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_valid;
    logic [31:0] fifo_data;
    logic        fifo_pop;
    logic        axis_tvalid;
    logic [31:0] axis_tdata;
    logic        axis_tlast;
    logic        axis_tready;
    logic        busy;
    logic        len_err;
`ifdef FIFO_AXIS_OUT_PKT_CNT_EN
    logic [31:0] pkt_cnt;
`endif

    fifo_axis_out #(.WIDTH(32), .LEN_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_valid  (fifo_valid),
        .fifo_data   (fifo_data),
        .fifo_pop    (fifo_pop),
        .axis_tvalid (axis_tvalid),
        .axis_tdata  (axis_tdata),
        .axis_tlast  (axis_tlast),
        .axis_tready (axis_tready),
        .busy        (busy),
        .len_err     (len_err)
`ifdef FIFO_AXIS_OUT_PKT_CNT_EN
        ,
        .pkt_cnt     (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int rdy_pct;
        int vld_pct;
        int exp_pops;
        int exp_lasts;
    } vec_t;

    logic [31:0] src_q[$];
    logic [32:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pop_cnt = 0;
    int          beat_cnt = 0;
    int          last_cnt = 0;
    int          pkt_model = 0;
    int          rdy_pct = 100;
    int          vld_pct = 100;
    logic [63:0] pop_log, vld_log, busy_log, err_log;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_beat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        fifo_valid  = (src_q.size() > 0) && (int'($urandom_range(99)) < vld_pct);
        fifo_data   = (src_q.size() > 0) ? src_q[0] : 32'd0;
        axis_tready = (int'($urandom_range(99)) < rdy_pct);
    endtask

    task automatic mark();
        cyc      = 0;
        pop_log  = '0;
        vld_log  = '0;
        busy_log = '0;
        err_log  = '0;
    endtask

    task automatic add_packet(input int len, input logic [31:0] base);
        src_q.push_back(32'h5A5A_0000 | 32'(len));
        for (int i = 0; i < len; i++) begin
            src_q.push_back(base + 32'(i));
            exp_q.push_back({(i == len - 1), base + 32'(i)});
        end
        drive();
    endtask

    task automatic step();
        logic        pop_now;
        logic [31:0] dropped;
        logic [32:0] e;
        @(negedge clk);
        if (cyc < 64) begin
            pop_log[cyc]  = fifo_pop;
            vld_log[cyc]  = axis_tvalid;
            busy_log[cyc] = busy;
            err_log[cyc]  = len_err;
        end
        pop_now = fifo_pop;
        if (fifo_pop) pop_cnt++;
        if (rst_n && prev_stall) begin
            check("hold_valid", 64'(axis_tvalid), 64'd1);
            check("hold_beat", 64'({axis_tlast, axis_tdata}), 64'(prev_beat));
        end
        if (axis_tvalid && axis_tready) begin
            beat_cnt++;
            if (axis_tlast) begin
                last_cnt++;
                pkt_model++;
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %0h expected none", {axis_tlast, axis_tdata});
            end else begin
                e = exp_q.pop_front();
                check("beat", 64'({axis_tlast, axis_tdata}), 64'(e));
            end
        end
        prev_stall = rst_n && axis_tvalid && !axis_tready;
        prev_beat  = {axis_tlast, axis_tdata};
        @(posedge clk);
        #1;
        if (pop_now && src_q.size() > 0) dropped = src_q.pop_front();
        cyc++;
        drive();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending beats expected 0", exp_q.size());
        end
        repeat (3) step();
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{len: 1,  rdy_pct: 100, vld_pct: 100, exp_pops: 2,  exp_lasts: 1};
        vecs[1] = '{len: 4,  rdy_pct: 50,  vld_pct: 100, exp_pops: 5,  exp_lasts: 1};
        vecs[2] = '{len: 7,  rdy_pct: 30,  vld_pct: 60,  exp_pops: 8,  exp_lasts: 1};
        vecs[3] = '{len: 2,  rdy_pct: 80,  vld_pct: 40,  exp_pops: 3,  exp_lasts: 1};
        vecs[4] = '{len: 16, rdy_pct: 100, vld_pct: 100, exp_pops: 17, exp_lasts: 1};
        vecs[5] = '{len: 9,  rdy_pct: 25,  vld_pct: 25,  exp_pops: 10, exp_lasts: 1};

        rst_n       = 1'b0;
        fifo_valid  = 1'b0;
        fifo_data   = 32'd0;
        axis_tready = 1'b1;
        @(posedge clk);
        #1;

        // Reset state, with a header already waiting in the FIFO.
        add_packet(3, 32'hA000_0001);
        step();
        check("rst_tvalid", 64'(axis_tvalid), 64'd0);
        check("rst_tdata", 64'(axis_tdata), 64'd0);
        check("rst_tlast", 64'(axis_tlast), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        check("rst_fifo_pop", 64'(fifo_pop), 64'd0);

        // Single packet timing.
        rst_n = 1'b1;
        mark();
        drain(100);
        check("single_pops", 64'(pop_log[4:0]), 64'b01111);
        check("single_valid", 64'(vld_log[5:0]), 64'b011100);
        check("single_busy5", 64'(busy_log[5]), 64'd0);

        // Back-to-back packets: one idle cycle between them.
        mark();
        add_packet(2, 32'hB100_0000);
        add_packet(1, 32'hB200_0000);
        drain(100);
        check("b2b_pops", 64'(pop_log[5:0]), 64'b011111);
        check("b2b_valid", 64'(vld_log[5:2]), 64'b1011);

        // Backpressure: 10 stall cycles, then full rate.
        rdy_pct = 0;
        mark();
        add_packet(5, 32'hC000_0010);
        pop_cnt = 0;
        repeat (10) step();
        check("bp_pops", 64'(pop_cnt), 64'd3);
        check("bp_tvalid", 64'(axis_tvalid), 64'd1);
        check("bp_tdata", 64'(axis_tdata), 64'hC000_0010);
        rdy_pct = 100;
        drive();
        mark();
        drain(100);
        check("bp_valid_run", 64'(vld_log[4:0]), 64'b11111);

        // Table-driven random-handshake packets.
        for (int v = 0; v < 6; v++) begin
            rdy_pct  = vecs[v].rdy_pct;
            vld_pct  = vecs[v].vld_pct;
            pop_cnt  = 0;
            last_cnt = 0;
            add_packet(vecs[v].len, 32'hD000_0000 + 32'(v << 8));
            drain(2000);
            check("vec_pops", 64'(pop_cnt), 64'(vecs[v].exp_pops));
            check("vec_lasts", 64'(last_cnt), 64'(vecs[v].exp_lasts));
        end
        rdy_pct = 100;
        vld_pct = 100;

        // Zero-length header followed by a one-beat packet.
        mark();
        last_cnt = 0;
        src_q.push_back(32'h5A5A_0000);
        add_packet(1, 32'hE000_00D1);
        drain(100);
        check("zl_err_c0", 64'(err_log[0]), 64'd0);
        check("zl_err_c1", 64'(err_log[1]), 64'd1);
        check("zl_lasts", 64'(last_cnt), 64'd1);
        check("zl_err_sticky", 64'(len_err), 64'd1);

        // Reset after 2 of 4 data beats are popped.
        rdy_pct = 0;
        src_q.push_back(32'h0000_0004);
        src_q.push_back(32'h1111_0005);
        src_q.push_back(32'h2222_0003);
        src_q.push_back(32'hCAFE_0001);
        src_q.push_back(32'h1234_5678);
        drive();
        pop_cnt = 0;
        for (int n = 0; n < 20 && pop_cnt < 3; n++) step();
        check("mr_pops", 64'(pop_cnt), 64'd3);
        rst_n = 1'b0;
        #1;
        check("mr_tvalid", 64'(axis_tvalid), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_fifo_pop", 64'(fifo_pop), 64'd0);
        pkt_model = 0;
        repeat (2) step();
        rst_n   = 1'b1;
        rdy_pct = 100;
        exp_q.push_back({1'b1, 32'h1234_5678});
        drive();
        check("mr_len_err", 64'(len_err), 64'd0);
        last_cnt = 0;
        drain(100);
        check("mr_lasts", 64'(last_cnt), 64'd1);

        // Maximum length packet.
        beat_cnt = 0;
        last_cnt = 0;
        add_packet(65535, 32'h0000_0000);
        drain(70000);
        check("max_beats", 64'(beat_cnt), 64'd65535);
        check("max_lasts", 64'(last_cnt), 64'd1);
        check("max_busy", 64'(busy), 64'd0);
        check("max_idle_pop", 64'(fifo_pop), 64'd0);

`ifdef FIFO_AXIS_OUT_PKT_CNT_EN
        check("pkt_cnt", 64'(pkt_cnt), 64'(pkt_model));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
